module_hit: RTL and testbench

// - Small fully-associative address tag store with hit detection, used by the branch prediction unit.
// - Allocates PC/target addresses round-robin on write requests.
// - On every cycle it compares addr_i against all valid entries.
// - Reports hit, the matching entry index and the stored word.

---
 rtl/module_hit.sv | 119 +++++++++++
 tb/tb_module_hit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/module_hit.sv
// module_hit: small fully-associative tag store with hit detection for the branch
// prediction unit. Addresses are allocated round-robin on write requests that miss;
// every cycle addr_i is compared against all valid entries.
//
// Parameters:
//   largo  highest entry index (entries = largo+1), legal range 1..7
//   ancho  width of stored word, addr_i and data_o
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   addr_i     lookup / allocate address
//   we_i       allocate request
//   data_o     stored word of the matching entry, 0 on miss
//   set_o      store full (all entries valid); sticky until reset
//   set        index of the lowest matching entry, 0 on miss
//   set_conta  round-robin allocation pointer (next entry to be written)
//   hit_o      addr_i matches a valid entry
//
// Configuration macro HIT_OUTPUT_REG_EN: when defined, hit_o/set/data_o are registered
// (one cycle latency); allocation still uses the combinational match.
module module_hit #(
    parameter int unsigned largo = 7,
    parameter int unsigned ancho = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ancho-1:0] addr_i,
    input  logic             we_i,
    output logic [ancho-1:0] data_o,
    output logic             set_o,
    output logic [2:0]       set,
    output logic [2:0]       set_conta,
    output logic             hit_o
);

    localparam int unsigned Entries = largo + 1;

    logic [ancho-1:0]   mem_q [Entries];
    logic [Entries-1:0] valid_q;
    logic [2:0]         conta_q;

    logic               match_hit;
    logic [2:0]         match_idx;
    logic [ancho-1:0]   match_data;
    logic               alloc;

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        match_hit  = 1'b0;
        match_idx  = '0;
        match_data = '0;
        for (int i = Entries - 1; i >= 0; i--) begin
            if (valid_q[i] && (mem_q[i] == addr_i)) begin
                match_hit  = 1'b1;
                match_idx  = 3'(i);
                match_data = mem_q[i];
            end
        end
    end

    // Only misses allocate, so duplicate tags can never exist.
    assign alloc = we_i && !match_hit;

    // Tag storage carries no reset; stale tags are masked by valid_q.
    always_ff @(posedge clk) begin
        if (alloc && reset) begin
            for (int i = 0; i < Entries; i++) begin
                if (conta_q == 3'(i)) begin
                    mem_q[i] <= addr_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            conta_q <= '0;
        end else if (alloc) begin
            for (int i = 0; i < Entries; i++) begin
                if (conta_q == 3'(i)) begin
                    valid_q[i] <= 1'b1;
                end
            end
            conta_q <= (conta_q == 3'(largo)) ? 3'd0 : conta_q + 3'd1;
        end
    end

    assign set_o     = &valid_q;
    assign set_conta = conta_q;

`ifdef HIT_OUTPUT_REG_EN
    logic             hit_q;
    logic [2:0]       set_q;
    logic [ancho-1:0] data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q  <= 1'b0;
            set_q  <= '0;
            data_q <= '0;
        end else begin
            hit_q  <= match_hit;
            set_q  <= match_idx;
            data_q <= match_data;
        end
    end

    assign hit_o  = hit_q;
    assign set    = set_q;
    assign data_o = data_q;
`else
    assign hit_o  = match_hit;
    assign set    = match_idx;
    assign data_o = match_data;
`endif

endmodule

// File: tb/tb_module_hit.sv
module tb_module_hit;

    localparam int unsigned Largo = 7;
    localparam int unsigned Ancho = 32;
    localparam int unsigned N     = Largo + 1;
`ifdef HIT_OUTPUT_REG_EN
    localparam bit RegMode = 1'b1;
`else
    localparam bit RegMode = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [Ancho-1:0] addr_i = '0;
    logic             we_i = 1'b0;
    logic [Ancho-1:0] data_o;
    logic             set_o;
    logic [2:0]       set;
    logic [2:0]       set_conta;
    logic             hit_o;

    module_hit #(
        .largo(Largo),
        .ancho(Ancho)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .data_o   (data_o),
        .set_o    (set_o),
        .set      (set),
        .set_conta(set_conta),
        .hit_o    (hit_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Reference model: a plain table of tags plus a circular pointer.
    logic [Ancho-1:0] m_mem [N];
    logic             m_valid [N];
    int               m_ptr;
    // Lookup result as seen just before the last active edge (registered-output mode).
    logic             r_hit;
    logic [2:0]       r_set;
    logic [Ancho-1:0] r_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [Ancho-1:0] a, output logic h,
                                   output logic [2:0] s, output logic [Ancho-1:0] d);
        h = 1'b0;
        s = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (!h && m_valid[i] && m_mem[i] == a) begin
                h = 1'b1;
                s = 3'(i);
                d = m_mem[i];
            end
        end
    endfunction

    function automatic logic model_full();
        logic f = 1'b1;
        for (int i = 0; i < N; i++) f = f & m_valid[i];
        return f;
    endfunction

    always @(negedge reset) begin
        for (int i = 0; i < N; i++) m_valid[i] <= 1'b0;
        m_ptr  <= 0;
        r_hit  <= 1'b0;
        r_set  <= '0;
        r_data <= '0;
    end

    always @(posedge clk) begin : model_upd
        logic             h;
        logic [2:0]       s;
        logic [Ancho-1:0] d;
        if (reset) begin
            lookup(addr_i, h, s, d);
            r_hit  <= h;
            r_set  <= s;
            r_data <= d;
            if (we_i && !h) begin
                m_mem[m_ptr]   <= addr_i;
                m_valid[m_ptr] <= 1'b1;
                m_ptr          <= (m_ptr == int'(Largo)) ? 0 : m_ptr + 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic             h;
        logic [2:0]       s;
        logic [Ancho-1:0] d;
        if (cmp_en) begin
            lookup(addr_i, h, s, d);
            check("hit_o", 64'(hit_o), 64'(RegMode ? r_hit : h));
            check("set", 64'(set), 64'(RegMode ? r_set : s));
            check("data_o", 64'(data_o), 64'(RegMode ? r_data : d));
            check("set_conta", 64'(set_conta), 64'(m_ptr));
            check("set_o", 64'(set_o), 64'(model_full()));
        end
    end

    task automatic drive(input logic we, input logic [Ancho-1:0] a);
        @(posedge clk);
        #1;
        we_i   = we;
        addr_i = a;
    endtask

    // Hold current inputs through one edge so both output modes have settled.
    task automatic settle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #4 reset = 1'b1;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        cmp_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_hit", 64'(hit_o), 64'd0);
        check("rst_set", 64'(set), 64'd0);
        check("rst_conta", 64'(set_conta), 64'd0);
        check("rst_full", 64'(set_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);

        // Repeated write of the same address allocates only once
        drive(1'b1, 32'hAABBCCDD);
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("rep_conta", 64'(set_conta), 64'd1);
        check("rep_hit", 64'(hit_o), 64'd1);
        check("rep_set", 64'(set), 64'd0);
        check("rep_data", 64'(data_o), 64'hAABBCCDD);

        drive(1'b0, 32'hAABBCCDD);
        settle();
        check("look_hit", 64'(hit_o), 64'd1);
        check("look_data", 64'(data_o), 64'hAABBCCDD);

        drive(1'b0, 32'hFFEEDDCC);
        settle();
        check("miss_hit", 64'(hit_o), 64'd0);
        check("miss_set", 64'(set), 64'd0);
        check("miss_data", 64'(data_o), 64'd0);
        check("miss_conta", 64'(set_conta), 64'd1);

        // Fill, then wrap and replace the oldest entry
        pulse_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h100 + 32'(i));
        drive(1'b0, 32'h0);
        @(negedge clk);
        check("full_set_o", 64'(set_o), 64'd1);
        check("full_conta", 64'(set_conta), 64'd0);
        drive(1'b1, 32'h200);
        drive(1'b0, 32'h100);
        settle();
        check("evict_hit", 64'(hit_o), 64'd0);
        check("evict_conta", 64'(set_conta), 64'd1);
        check("evict_full", 64'(set_o), 64'd1);
        drive(1'b0, 32'h200);
        settle();
        check("new_hit", 64'(hit_o), 64'd1);
        check("new_set", 64'(set), 64'd0);
        drive(1'b0, 32'h107);
        settle();
        check("last_set", 64'(set), 64'd7);

        // Reset during an allocation aborts it
        drive(1'b1, 32'h300);
        #3 reset = 1'b0;
        #1;
        check("abort_hit", 64'(hit_o), 64'd0);
        check("abort_full", 64'(set_o), 64'd0);
        check("abort_conta", 64'(set_conta), 64'd0);
        @(posedge clk);
        #1;
        we_i   = 1'b0;
        reset  = 1'b1;
        settle();
        check("abort_look", 64'(hit_o), 64'd0);

        // Randomized traffic over a small address pool so hits are frequent
        for (int n = 0; n < 800; n++) begin
            @(posedge clk);
            #1;
            we_i   = ($urandom_range(0, 1) == 1);
            addr_i = ($urandom_range(0, 15) == 0) ? $urandom()
                                                  : 32'h1000 + 32'($urandom_range(0, 11));
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b0;
                #4 reset = 1'b1;
            end
        end
        @(negedge clk);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
